mem_io_responder: RTL and testbench

- Responder end of the CPU's byte-wide memory bus (address, write strobe, data out, data in).
- Serves the 128 KB RAM region and the memory-mapped I/O window at mem_a[17:16]==2'b11.
- I/O window provides a UART-side RX/TX byte FIFO pair, a free-running cycle counter and a program-stop flag.
- Generates the rdy signal that pauses the CPU while an I/O access cannot complete.

---
 rtl/mem_io_responder.sv | 153 +++++++++++++++
 tb/tb_mem_io_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: 128 KB RAM plus an I/O window at 0x30000
// with RX/TX byte FIFOs, a free-running cycle counter and a program-stop flag.

module mem_io_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp, rp;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + ONE;
            if (pop)  rp <= rp + ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop
);
    typedef struct packed {
        logic rd_rx;
        logic wr_tx;
        logic wr_stop;
        logic rd_cnt;
    } io_req_t;

    logic [7:0]  ram [2**ADDR_WIDTH];
    logic [31:0] cnt;
    logic [23:0] snap;
    logic        io_sel;
    logic [15:0] off;
    io_req_t     req;
    logic        rx_empty, rx_full, rx_pop;
    logic [7:0]  rx_head;
    logic        tx_empty, tx_full, tx_push;
    logic [7:0]  tx_wdata;
    logic        unused_hi;

    assign unused_hi = ^mem_a[31:18];

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign off         = mem_a[15:0];
    assign req.rd_rx   = io_sel && !mem_wr && (off == 16'h0000);
    assign req.wr_tx   = io_sel &&  mem_wr && (off == 16'h0000) && (mem_dout != 8'h00);
    assign req.wr_stop = io_sel &&  mem_wr && (off == 16'h0004);
    assign req.rd_cnt  = io_sel && !mem_wr && (off[15:2] == 14'd1);

    // Stalls look only at registered full/empty, never at same-cycle pops.
    assign rdy_out  = !((req.rd_rx && rx_empty) ||
                        ((req.wr_tx || req.wr_stop) && tx_full));
    assign rx_pop   = req.rd_rx && !rx_empty;
    assign tx_push  = (req.wr_tx || req.wr_stop) && !tx_full;
    assign tx_wdata = req.wr_stop ? 8'h00 : mem_dout;
    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    mem_io_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk_in(clk_in), .rst_in(rst_in),
        .push(rx_valid && !rx_full), .wdata(rx_data),
        .pop(rx_pop), .rdata(rx_head), .empty(rx_empty), .full(rx_full)
    );

    mem_io_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk_in(clk_in), .rst_in(rst_in),
        .push(tx_push), .wdata(tx_wdata),
        .pop(tx_valid && tx_ready), .rdata(tx_data), .empty(tx_empty), .full(tx_full)
    );

    always_ff @(posedge clk_in) begin
        if (!io_sel && mem_wr) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) cnt <= '0;
        else        cnt <= cnt + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prog_stop <= 1'b0;
        end else if (req.wr_stop && !tx_full) begin
            prog_stop <= 1'b1;
        end
    end

    // Byte 0 of the counter snapshots the upper bytes so later reads are coherent.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
            snap    <= '0;
        end else if (rdy_out && !mem_wr) begin
            if (!io_sel) begin
                mem_din <= ram[mem_a[ADDR_WIDTH-1:0]];
            end else if (req.rd_rx) begin
                mem_din <= rx_head;
            end else if (req.rd_cnt) begin
                case (off[1:0])
                    2'd0: begin
                        mem_din <= cnt[7:0];
                        snap    <= cnt[31:8];
                    end
                    2'd1: mem_din <= snap[7:0];
                    2'd2: mem_din <= snap[15:8];
                    default: mem_din <= snap[23:16];
                endcase
            end else begin
                mem_din <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, RX/TX FIFOs, counter, stop flag, reset.

module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'h0003_0008;
    logic        mem_wr = 1'b1;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        prog_stop;

    int ntests = 0;
    int nfail  = 0;
    logic [31:0] tbc;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .rdy_out(rdy_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .prog_stop(prog_stop)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle count: cleared by reset, +1 on every edge after.
    always @(posedge clk_in) begin
        if (rst_in) tbc <= 32'd0;
        else        tbc <= tbc + 32'd1;
    end

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a = a; mem_wr = wr; mem_dout = d;
    endtask

    task automatic idle();
        drive(32'h0003_0008, 1'b1, 8'h00);
    endtask

    task automatic test_reset();
        @(negedge clk_in); rst_in = 1'b1; idle();
        @(negedge clk_in); rst_in = 1'b0;
        #1;
        ntests++; if (mem_din !== 8'h00) begin nfail++; $display("FAIL reset_mem_din got %h want 00", mem_din); end
        ntests++; if (prog_stop !== 1'b0) begin nfail++; $display("FAIL reset_prog_stop got %b want 0", prog_stop); end
        ntests++; if (tx_valid !== 1'b0) begin nfail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        ntests++; if (rx_ready !== 1'b1) begin nfail++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        ntests++; if (rdy_out !== 1'b1) begin nfail++; $display("FAIL reset_rdy got %b want 1", rdy_out); end
    endtask

    task automatic test_ram();
        @(negedge clk_in); drive(32'h0000_0010, 1'b1, 8'hA5); #1;
        ntests++; if (rdy_out !== 1'b1) begin nfail++; $display("FAIL ram_wr_rdy got %b want 1", rdy_out); end
        @(negedge clk_in); drive(32'h0000_0010, 1'b0, 8'h00); #1;
        ntests++; if (rdy_out !== 1'b1) begin nfail++; $display("FAIL ram_rd_rdy got %b want 1", rdy_out); end
        @(negedge clk_in); drive(32'h0000_0011, 1'b1, 8'h3C); #1;
        ntests++; if (mem_din !== 8'hA5) begin nfail++; $display("FAIL ram_rd got %h want a5", mem_din); end
        @(negedge clk_in); drive(32'h0002_0011, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'hA5) begin nfail++; $display("FAIL ram_wr_keeps_din got %h want a5", mem_din); end
        @(negedge clk_in); drive(32'h0002_0010, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'h3C) begin nfail++; $display("FAIL ram_alias_rd got %h want 3c", mem_din); end
        @(negedge clk_in); idle(); #1;
        ntests++; if (mem_din !== 8'hA5) begin nfail++; $display("FAIL ram_alias_rd2 got %h want a5", mem_din); end
    endtask

    task automatic test_rx();
        @(negedge clk_in); drive(32'h0003_0000, 1'b0, 8'h00); rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL rx_empty_stall[%0d] got %b want 0", i, rdy_out); end
            ntests++; if (mem_din !== 8'hA5) begin nfail++; $display("FAIL rx_stall_din[%0d] got %h want a5", i, mem_din); end
            @(negedge clk_in);
        end
        rx_data = 8'h41; rx_valid = 1'b1;
        @(negedge clk_in); rx_valid = 1'b0; #1;
        ntests++; if (rdy_out !== 1'b1) begin nfail++; $display("FAIL rx_unstall got %b want 1", rdy_out); end
        @(negedge clk_in); #1;
        ntests++; if (mem_din !== 8'h41) begin nfail++; $display("FAIL rx_pop_data got %h want 41", mem_din); end
        ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL rx_empty_again got %b want 0", rdy_out); end
        @(negedge clk_in); idle();
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        @(negedge clk_in); drive(32'h0003_0000, 1'b1, 8'h48); #1;
        ntests++; if (rdy_out !== 1'b1) begin nfail++; $display("FAIL tx_wr_rdy got %b want 1", rdy_out); end
        @(negedge clk_in); drive(32'h0003_0000, 1'b1, 8'h00); #1;
        ntests++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin nfail++; $display("FAIL tx_first got v=%b d=%h want v=1 d=48", tx_valid, tx_data); end
        @(negedge clk_in); drive(32'h0003_0000, 1'b1, 8'h49);
        @(negedge clk_in); idle(); tx_ready = 1'b1; #1;
        ntests++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin nfail++; $display("FAIL tx_out0 got v=%b d=%h want v=1 d=48", tx_valid, tx_data); end
        @(negedge clk_in); #1;
        ntests++; if (tx_valid !== 1'b1 || tx_data !== 8'h49) begin nfail++; $display("FAIL tx_out1 got v=%b d=%h want v=1 d=49", tx_valid, tx_data); end
        @(negedge clk_in); #1;
        ntests++; if (tx_valid !== 1'b0) begin nfail++; $display("FAIL tx_drained got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_full();
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in); drive(32'h0003_0000, 1'b1, 8'(i + 1));
        end
        @(negedge clk_in); drive(32'h0003_0004, 1'b1, 8'h00); #1;
        ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL tx_full_stop_stall got %b want 0", rdy_out); end
        @(negedge clk_in); #1;
        ntests++; if (prog_stop !== 1'b0) begin nfail++; $display("FAIL tx_full_stop_flag got %b want 0", prog_stop); end
        drive(32'h0003_0000, 1'b1, 8'h77); #1;
        ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL tx_full_stall got %b want 0", rdy_out); end
        @(negedge clk_in); tx_ready = 1'b1; #1;
        ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL tx_same_cycle_pop got %b want 0", rdy_out); end
        @(negedge clk_in); tx_ready = 1'b0; #1;
        ntests++; if (rdy_out !== 1'b1) begin nfail++; $display("FAIL tx_unstall got %b want 1", rdy_out); end
        @(negedge clk_in); drive(32'h0003_0000, 1'b1, 8'h55); #1;
        ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL tx_refull got %b want 0", rdy_out); end
        @(negedge clk_in); idle(); tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = (k == 15) ? 8'h77 : 8'(k + 2);
            #1;
            ntests++; if (tx_valid !== 1'b1 || tx_data !== exp) begin nfail++; $display("FAIL tx_drain[%0d] got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, exp); end
            @(negedge clk_in);
        end
        #1;
        ntests++; if (tx_valid !== 1'b0) begin nfail++; $display("FAIL tx_full_drained got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        for (int i = 0; i < 20000 && tbc != 32'h0000_12FF; i++) @(negedge clk_in);
        ntests++; if (tbc !== 32'h0000_12FF) begin nfail++; $display("FAIL cnt_wait got %h want 000012ff", tbc); end
        drive(32'h0003_0004, 1'b0, 8'h00);
        @(negedge clk_in); drive(32'h0003_0005, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'hFF) begin nfail++; $display("FAIL cnt_b0 got %h want ff", mem_din); end
        @(negedge clk_in); drive(32'h0003_0006, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'h12) begin nfail++; $display("FAIL cnt_b1 got %h want 12", mem_din); end
        @(negedge clk_in); drive(32'h0003_0007, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'h00) begin nfail++; $display("FAIL cnt_b2 got %h want 00", mem_din); end
        @(negedge clk_in); drive(32'h0003_0010, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'h00) begin nfail++; $display("FAIL cnt_b3 got %h want 00", mem_din); end
        @(negedge clk_in); exp = tbc; drive(32'h0003_0004, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== 8'h00) begin nfail++; $display("FAIL io_other_rd got %h want 00", mem_din); end
        @(negedge clk_in); drive(32'h0003_0005, 1'b0, 8'h00); #1;
        ntests++; if (mem_din !== exp[7:0]) begin nfail++; $display("FAIL cnt_resnap_b0 got %h want %h", mem_din, exp[7:0]); end
        @(negedge clk_in); idle(); #1;
        ntests++; if (mem_din !== exp[15:8]) begin nfail++; $display("FAIL cnt_resnap_b1 got %h want %h", mem_din, exp[15:8]); end
    endtask

    task automatic test_rx_full();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in); rx_valid = 1'b1; rx_data = 8'(8'h60 + k);
        end
        @(negedge clk_in); rx_valid = 1'b0; #1;
        ntests++; if (rx_ready !== 1'b0) begin nfail++; $display("FAIL rx_full got %b want 0", rx_ready); end
        drive(32'h0003_0000, 1'b0, 8'h00);
        @(negedge clk_in); idle(); #1;
        ntests++; if (mem_din !== 8'h60 || rx_ready !== 1'b1) begin nfail++; $display("FAIL rx_full_pop got d=%h r=%b want d=60 r=1", mem_din, rx_ready); end
    endtask

    task automatic test_stop_reset();
        tx_ready = 1'b0;
        @(negedge clk_in); drive(32'h0003_0004, 1'b1, 8'h00);
        @(negedge clk_in); idle(); #1;
        ntests++; if (prog_stop !== 1'b1) begin nfail++; $display("FAIL stop_flag got %b want 1", prog_stop); end
        ntests++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin nfail++; $display("FAIL stop_tx got v=%b d=%h want v=1 d=00", tx_valid, tx_data); end
        @(negedge clk_in); @(negedge clk_in); #1;
        ntests++; if (prog_stop !== 1'b1) begin nfail++; $display("FAIL stop_sticky got %b want 1", prog_stop); end
        rst_in = 1'b1;
        @(negedge clk_in); rst_in = 1'b0; #1;
        ntests++; if (prog_stop !== 1'b0) begin nfail++; $display("FAIL rst_prog_stop got %b want 0", prog_stop); end
        ntests++; if (tx_valid !== 1'b0) begin nfail++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        ntests++; if (mem_din !== 8'h00) begin nfail++; $display("FAIL rst_mem_din got %h want 00", mem_din); end
        drive(32'h0003_0000, 1'b0, 8'h00); #1;
        ntests++; if (rdy_out !== 1'b0) begin nfail++; $display("FAIL rst_rx_flushed got %b want 0", rdy_out); end
        @(negedge clk_in); idle();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_rx();
        test_tx();
        test_tx_full();
        test_counter();
        test_rx_full();
        test_stop_reset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
